// File: rtl/fpga_rst_pkg.sv
// Shared types and constants for the FPGA reset sequencer.
// Holds the sequencer state encoding and the width of the reset event counter.
package fpga_rst_pkg;

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2
  } rst_state_e;

  localparam int RST_CNT_W = 8;

  // Saturating increment for the reset event counter; sticks at all-ones.
  function automatic logic [RST_CNT_W-1:0] sat_inc(input logic [RST_CNT_W-1:0] value);
    logic [RST_CNT_W-1:0] result;
    if (value == {RST_CNT_W{1'b1}}) begin
      result = value;
    end else begin
      result = value + RST_CNT_W'(1);
    end
    return result;
  endfunction

endpackage

// File: rtl/fpga_debounce.sv
// Synchroniser, polarity normalisation and stability counter for a raw pushbutton.
// stable_o is 1 while the debounced button is pressed.
module fpga_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit ACTIVE_HIGH     = 1'b1,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic stable_o
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pressed;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   stable_q;
  logic                   stable_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
    end
  end

  assign pressed = ACTIVE_HIGH ? sync_q[SYNC_STAGES-1] : ~sync_q[SYNC_STAGES-1];

  // Any cycle that agrees with the accepted level restarts the count, so a
  // level change only wins after DEBOUNCE_CYCLES uninterrupted disagreeing cycles.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (pressed != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = ~stable_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/fpga_rst_seq.sv
// Board-level reset sequencer: combines the pushbutton and clock-wizard lock into
// a clean system reset held for HOLD_CYCLES after both are good, and counts drops.
module fpga_rst_seq
  import fpga_rst_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 1024,
  parameter bit BTN_ACTIVE_HIGH = 1'b1,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 btn_i,
  input  logic                 pll_locked_i,
  output logic                 rst_no,
  output logic                 rst_led_o,
  output logic                 busy_o,
  output logic [RST_CNT_W-1:0] reset_count_o
);

  localparam int               HOLD_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [SYNC_STAGES-1:0] locked_sync_q;
  logic                   locked_sync;
  logic                   btn_db;
  logic                   abort;

  rst_state_e             state_q;
  rst_state_e             next_state;
  logic [HOLD_W-1:0]      hold_q;
  logic [HOLD_W-1:0]      hold_d;
  logic [RST_CNT_W-1:0]   count_q;
  logic [RST_CNT_W-1:0]   count_d;
  logic                   rst_q;

  fpga_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .ACTIVE_HIGH    (BTN_ACTIVE_HIGH),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_btn_db (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .raw_i   (btn_i),
    .stable_o(btn_db)
  );

  // The lock flag is a clean level from the clock wizard, so it only needs
  // synchronising, not debouncing.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      locked_sync_q <= '0;
    end else begin
      locked_sync_q <= {locked_sync_q[SYNC_STAGES-2:0], pll_locked_i};
    end
  end

  assign locked_sync = locked_sync_q[SYNC_STAGES-1];
  assign abort       = ~locked_sync | btn_db;

  always_comb begin
    next_state = state_q;
    hold_d     = '0;
    count_d    = count_q;
    case (state_q)
      WAIT: begin
        if (!abort) begin
          next_state = HOLD;
        end
      end
      HOLD: begin
        if (abort) begin
          next_state = WAIT;
        end else if (hold_q == HOLD_LAST) begin
          next_state = RUN;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      RUN: begin
        if (abort) begin
          next_state = WAIT;
          count_d    = sat_inc(count_q);
        end
      end
      default: begin
        next_state = WAIT;
      end
    endcase
  end

  // rst_q is registered from next_state so the released reset moves on the same
  // edge as the state and never glitches; the async clear asserts it at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= WAIT;
      hold_q  <= '0;
      count_q <= '0;
      rst_q   <= 1'b0;
    end else begin
      state_q <= next_state;
      hold_q  <= hold_d;
      count_q <= count_d;
      rst_q   <= (next_state == RUN);
    end
  end

  assign rst_no        = rst_q;
  assign rst_led_o     = rst_q;
  assign busy_o        = (state_q != RUN);
  assign reset_count_o = count_q;

endmodule

// File: tb/tb_fpga_rst_seq.sv
// Directed bench for fpga_rst_seq with short debounce/hold settings.
// Combines a table of steady-state vectors with hand-timed corner sequences.
module tb_fpga_rst_seq;

  localparam int DEBOUNCE = 8;
  localparam int HOLD     = 16;
  localparam int SYNC     = 2;

  logic       clk;
  logic       rst_ni;
  logic       btn_i;
  logic       pll_locked_i;
  logic       rst_no;
  logic       rst_led_o;
  logic       busy_o;
  logic [7:0] reset_count_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       btn;
    logic       pll;
    int         cycles;
    logic       exp_rst;
    logic       exp_busy;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs[12];

  fpga_rst_seq #(
    .DEBOUNCE_CYCLES(DEBOUNCE),
    .HOLD_CYCLES    (HOLD),
    .BTN_ACTIVE_HIGH(1'b1),
    .SYNC_STAGES    (SYNC)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .btn_i        (btn_i),
    .pll_locked_i (pll_locked_i),
    .rst_no       (rst_no),
    .rst_led_o    (rst_led_o),
    .busy_o       (busy_o),
    .reset_count_o(reset_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_state(input string name, input logic e_rst, input logic e_busy,
                             input int e_cnt);
    check_output({name, "_rst_no"}, int'(rst_no), int'(e_rst));
    check_output({name, "_led"}, int'(rst_led_o), int'(e_rst));
    check_output({name, "_busy"}, int'(busy_o), int'(e_busy));
    check_output({name, "_count"}, int'(reset_count_o), e_cnt);
  endtask

  // Counts edges until rst_no reaches level; -1 if the bound expires.
  task automatic wait_level(input logic level, input int limit, output int n);
    n = 0;
    while (1) begin
      tick();
      n++;
      if (rst_no == level) break;
      if (n >= limit) begin
        n = -1;
        break;
      end
    end
  endtask

  task automatic apply_stimulus(input logic b, input logic p);
    btn_i        = b;
    pll_locked_i = p;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int exp_cnt;

    // Entered in RUN with count 0 right after power-up.
    vecs[0]  = '{btn: 1'b0, pll: 1'b1, cycles: 4,  exp_rst: 1'b1, exp_busy: 1'b0, exp_cnt: 8'd0};
    vecs[1]  = '{btn: 1'b1, pll: 1'b1, cycles: 5,  exp_rst: 1'b1, exp_busy: 1'b0, exp_cnt: 8'd0};
    vecs[2]  = '{btn: 1'b0, pll: 1'b1, cycles: 12, exp_rst: 1'b1, exp_busy: 1'b0, exp_cnt: 8'd0};
    vecs[3]  = '{btn: 1'b1, pll: 1'b1, cycles: 10, exp_rst: 1'b1, exp_busy: 1'b0, exp_cnt: 8'd0};
    vecs[4]  = '{btn: 1'b1, pll: 1'b1, cycles: 1,  exp_rst: 1'b0, exp_busy: 1'b1, exp_cnt: 8'd1};
    vecs[5]  = '{btn: 1'b1, pll: 1'b1, cycles: 50, exp_rst: 1'b0, exp_busy: 1'b1, exp_cnt: 8'd1};
    vecs[6]  = '{btn: 1'b0, pll: 1'b1, cycles: 26, exp_rst: 1'b0, exp_busy: 1'b1, exp_cnt: 8'd1};
    vecs[7]  = '{btn: 1'b0, pll: 1'b1, cycles: 1,  exp_rst: 1'b1, exp_busy: 1'b0, exp_cnt: 8'd1};
    vecs[8]  = '{btn: 1'b0, pll: 1'b0, cycles: 2,  exp_rst: 1'b1, exp_busy: 1'b0, exp_cnt: 8'd1};
    vecs[9]  = '{btn: 1'b0, pll: 1'b0, cycles: 1,  exp_rst: 1'b0, exp_busy: 1'b1, exp_cnt: 8'd2};
    vecs[10] = '{btn: 1'b0, pll: 1'b1, cycles: 18, exp_rst: 1'b0, exp_busy: 1'b1, exp_cnt: 8'd2};
    vecs[11] = '{btn: 1'b0, pll: 1'b1, cycles: 1,  exp_rst: 1'b1, exp_busy: 1'b0, exp_cnt: 8'd2};

    rst_ni = 1'b0;
    apply_stimulus(1'b0, 1'b0);
    #1;
    check_state("por", 1'b0, 1'b1, 0);
    repeat (3) tick();
    check_state("por_clk", 1'b0, 1'b1, 0);
    rst_ni = 1'b1;

    // Power-up: lock rises after edge 10, release expected at edge 29.
    repeat (10) tick();
    check_state("prelock", 1'b0, 1'b1, 0);
    apply_stimulus(1'b0, 1'b1);
    wait_level(1'b1, 100, n);
    check_output("powerup_latency", 10 + n, 10 + SYNC + HOLD + 1);
    check_state("powerup", 1'b1, 1'b0, 0);

    for (int i = 0; i < 12; i++) begin
      apply_stimulus(vecs[i].btn, vecs[i].pll);
      repeat (vecs[i].cycles) tick();
      check_state($sformatf("vec%0d", i), vecs[i].exp_rst, vecs[i].exp_busy, int'(vecs[i].exp_cnt));
    end

    // Abort in HOLD: count a RUN drop first, then abort partway through HOLD.
    apply_stimulus(1'b0, 1'b0);
    wait_level(1'b0, 20, n);
    check_output("lockloss_latency", n, SYNC + 1);
    check_output("lockloss_count", int'(reset_count_o), 3);
    apply_stimulus(1'b0, 1'b1);
    repeat (12) tick();
    check_state("hold_mid", 1'b0, 1'b1, 3);
    apply_stimulus(1'b0, 1'b0);
    repeat (6) tick();
    check_state("hold_abort", 1'b0, 1'b1, 3);
    apply_stimulus(1'b0, 1'b1);
    wait_level(1'b1, 60, n);
    check_output("hold_restart_latency", n, SYNC + HOLD + 1);
    check_output("hold_restart_count", int'(reset_count_o), 3);

    // Async reset between edges while in RUN.
    tick();
    #2;
    rst_ni = 1'b0;
    #1;
    check_state("async_rst", 1'b0, 1'b1, 0);
    #2;
    rst_ni = 1'b1;
    wait_level(1'b1, 60, n);
    check_output("async_restart_latency", n, SYNC + HOLD + 1);
    check_output("async_restart_count", int'(reset_count_o), 0);

    // Saturation: 260 press/release events.
    for (int i = 0; i < 260; i++) begin
      apply_stimulus(1'b1, 1'b1);
      wait_level(1'b0, 40, n);
      check_output("sat_press_latency", n, SYNC + DEBOUNCE + 1);
      exp_cnt = (i + 1 > 255) ? 255 : i + 1;
      check_output($sformatf("sat_count%0d", i), int'(reset_count_o), exp_cnt);
      apply_stimulus(1'b0, 1'b1);
      wait_level(1'b1, 60, n);
      check_output("sat_release_latency", n, SYNC + DEBOUNCE + HOLD + 1);
    end
    check_state("sat_final", 1'b1, 1'b0, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
